// File: rtl/jt12_eg_state_pkg.sv
// Envelope phase encoding shared by the envelope state, rate and attenuation stages.
package jt12_eg_state_pkg;

    localparam int unsigned PHASE_W = 2;

    localparam logic [PHASE_W-1:0] ATTACK  = 2'd0;
    localparam logic [PHASE_W-1:0] DECAY   = 2'd1;
    localparam logic [PHASE_W-1:0] SUSTAIN = 2'd2;
    localparam logic [PHASE_W-1:0] RELEASE = 2'd3;

    // Sustain level 15 maps to the very bottom of the attenuation range.
    function automatic logic [4:0] sustain_threshold(input logic [3:0] sl);
        return (sl == 4'hF) ? 5'h1F : {1'b0, sl};
    endfunction

endpackage

// File: rtl/jt12_sh_rst.sv
// Circular per-slot context shift register with asynchronous reset to a fixed value.
module jt12_sh_rst #(
    parameter int unsigned width  = 3,
    parameter int unsigned stages = 24,
    parameter logic [width-1:0] rstval = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [width-1:0] din,
    output logic [width-1:0] drop
);

    logic [width-1:0] bits [stages];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(stages); i++) bits[i] <= rstval;
        end else if (cen) begin
            bits[0] <= din;
            for (int i = 1; i < int'(stages); i++) bits[i] <= bits[i-1];
        end
    end

    assign drop = bits[stages-1];

endmodule

// File: rtl/jt12_eg_state.sv
// Per-slot envelope phase tracker: key-on/off edge detection and phase/base-rate selection.
module jt12_eg_state
    import jt12_eg_state_pkg::*;
#(
    parameter int unsigned num_ch = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    input  logic               keyon_I,
    input  logic [9:0]         eg_att,
    input  logic [3:0]         sl,
    input  logic [4:0]         arate,
    input  logic [4:0]         rate1,
    input  logic [4:0]         rate2,
    input  logic [3:0]         rrate,
    output logic [PHASE_W-1:0] state,
    output logic [4:0]         base_rate,
    output logic               kon_edge,
    output logic               koff_edge
);

    localparam int unsigned SLOTS = 4 * num_ch;
    localparam int unsigned CTX_W = PHASE_W + 1;

    logic [CTX_W-1:0]   ctx_tail;
    logic [CTX_W-1:0]   ctx_head_c;
    logic [PHASE_W-1:0] phase_cur;
    logic               prev_kon;
    logic [PHASE_W-1:0] phase_nxt_c;
    logic [4:0]         base_rate_c;
    logic               kon_edge_c;
    logic               koff_edge_c;

    assign {phase_cur, prev_kon} = ctx_tail;

    // Key edges override any phase progression; otherwise advance attack/decay.
    always_comb begin
        phase_nxt_c = phase_cur;
        kon_edge_c  = 1'b0;
        koff_edge_c = 1'b0;
        base_rate_c = 5'd0;

        if (keyon_I && !prev_kon) begin
            phase_nxt_c = ATTACK;
            kon_edge_c  = 1'b1;
        end else if (!keyon_I && prev_kon) begin
            phase_nxt_c = RELEASE;
            koff_edge_c = 1'b1;
        end else if (phase_cur == ATTACK && eg_att == 10'd0) begin
            phase_nxt_c = DECAY;
        end else if (phase_cur == DECAY && eg_att[9:5] >= sustain_threshold(sl)) begin
            phase_nxt_c = SUSTAIN;
        end

        case (phase_nxt_c)
            ATTACK:  base_rate_c = arate;
            DECAY:   base_rate_c = rate1;
            SUSTAIN: base_rate_c = rate2;
            default: base_rate_c = {rrate, 1'b1};
        endcase
    end

    assign ctx_head_c = {phase_nxt_c, keyon_I};

    jt12_sh_rst #(
        .width (CTX_W),
        .stages(SLOTS),
        .rstval({RELEASE, 1'b0})
    ) u_ctx (
        .clk (clk),
        .rst (rst),
        .cen (clk_en),
        .din (ctx_head_c),
        .drop(ctx_tail)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RELEASE;
            base_rate <= 5'd0;
            kon_edge  <= 1'b0;
            koff_edge <= 1'b0;
        end else if (clk_en) begin
            state     <= phase_nxt_c;
            base_rate <= base_rate_c;
            kon_edge  <= kon_edge_c;
            koff_edge <= koff_edge_c;
        end
    end

endmodule

// File: tb/tb_jt12_eg_state.sv
// Directed vector bench for jt12_eg_state (24-slot main instance plus a 12-slot instance).
module tb_jt12_eg_state;
    import jt12_eg_state_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clk_en, keyon;
    logic       rst3, clk_en3, keyon3;
    logic [9:0] eg_att;
    logic [3:0] sl;
    logic [4:0] arate, rate1, rate2;
    logic [3:0] rrate;
    logic [1:0] state, state3;
    logic [4:0] base_rate, base3;
    logic       kon_edge, koff_edge, kon3, koff3;

    jt12_eg_state #(.num_ch(6)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .keyon_I(keyon), .eg_att(eg_att),
        .sl(sl), .arate(arate), .rate1(rate1), .rate2(rate2), .rrate(rrate),
        .state(state), .base_rate(base_rate), .kon_edge(kon_edge), .koff_edge(koff_edge)
    );

    jt12_eg_state #(.num_ch(3)) dut3 (
        .clk(clk), .rst(rst3), .clk_en(clk_en3), .keyon_I(keyon3), .eg_att(eg_att),
        .sl(sl), .arate(arate), .rate1(rate1), .rate2(rate2), .rrate(rrate),
        .state(state3), .base_rate(base3), .kon_edge(kon3), .koff_edge(koff3)
    );

    typedef struct {
        int         slot;
        logic       kon;
        logic [9:0] att;
        logic [3:0] sl;
        int         stall;
        logic [1:0] e_state;
        logic [4:0] e_base;
        logic       e_kon;
        logic       e_koff;
    } vec_t;

    vec_t       vecs [18];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cnt;
    logic       kon_hold [24];
    logic [9:0] att_hold [24];
    logic [3:0] sl_hold  [24];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic check_out(input string name, input int es, input int eb, input int ek, input int ef);
        check({name, "_state"}, int'(state), es);
        check({name, "_base"},  int'(base_rate), eb);
        check({name, "_kon"},   int'(kon_edge), ek);
        check({name, "_koff"},  int'(koff_edge), ef);
    endtask

    task automatic check_out3(input string name, input int es, input int eb, input int ek, input int ef);
        check({name, "_state"}, int'(state3), es);
        check({name, "_base"},  int'(base3), eb);
        check({name, "_kon"},   int'(kon3), ek);
        check({name, "_koff"},  int'(koff3), ef);
    endtask

    task automatic tick(input logic k, input logic [9:0] a, input logic [3:0] s);
        keyon  = k;
        eg_att = a;
        sl     = s;
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        cnt = (cnt + 1) % 24;
    endtask

    task automatic goto_slot(input int s);
        for (int i = 0; i < 24 && cnt != s; i++)
            tick(kon_hold[cnt], att_hold[cnt], sl_hold[cnt]);
    endtask

    task automatic clear_holds();
        cnt = 0;
        for (int i = 0; i < 24; i++) begin
            kon_hold[i] = 1'b0;
            att_hold[i] = 10'h3FF;
            sl_hold[i]  = 4'h0;
        end
    endtask

    initial begin
        //          slot kon  att      sl    stall st    base    kon   koff
        vecs[0]  = '{0,  1'b1, 10'h3FF, 4'h0, 0, 2'd0, 5'h11, 1'b1, 1'b0};
        vecs[1]  = '{5,  1'b1, 10'h100, 4'h0, 0, 2'd0, 5'h11, 1'b1, 1'b0};
        vecs[2]  = '{5,  1'b1, 10'h100, 4'h0, 0, 2'd0, 5'h11, 1'b0, 1'b0};
        vecs[3]  = '{5,  1'b1, 10'h100, 4'h0, 0, 2'd0, 5'h11, 1'b0, 1'b0};
        vecs[4]  = '{5,  1'b1, 10'h000, 4'h0, 0, 2'd1, 5'h12, 1'b0, 1'b0};
        vecs[5]  = '{5,  1'b1, 10'h05F, 4'h3, 0, 2'd1, 5'h12, 1'b0, 1'b0};
        vecs[6]  = '{5,  1'b1, 10'h060, 4'h3, 5, 2'd2, 5'h13, 1'b0, 1'b0};
        vecs[7]  = '{5,  1'b0, 10'h060, 4'h3, 0, 2'd3, 5'h0F, 1'b0, 1'b1};
        vecs[8]  = '{5,  1'b0, 10'h060, 4'h3, 0, 2'd3, 5'h0F, 1'b0, 1'b0};
        vecs[9]  = '{7,  1'b1, 10'h000, 4'hF, 0, 2'd0, 5'h11, 1'b1, 1'b0};
        vecs[10] = '{7,  1'b1, 10'h000, 4'hF, 0, 2'd1, 5'h12, 1'b0, 1'b0};
        vecs[11] = '{7,  1'b1, 10'h3DF, 4'hF, 0, 2'd1, 5'h12, 1'b0, 1'b0};
        vecs[12] = '{7,  1'b1, 10'h3E0, 4'hF, 0, 2'd2, 5'h13, 1'b0, 1'b0};
        vecs[13] = '{0,  1'b1, 10'h3FF, 4'h0, 0, 2'd0, 5'h11, 1'b0, 1'b0};
        vecs[14] = '{23, 1'b1, 10'h200, 4'h0, 0, 2'd0, 5'h11, 1'b1, 1'b0};
        vecs[15] = '{23, 1'b0, 10'h200, 4'h0, 0, 2'd3, 5'h0F, 1'b0, 1'b1};
        vecs[16] = '{23, 1'b1, 10'h200, 4'h0, 0, 2'd0, 5'h11, 1'b1, 1'b0};
        vecs[17] = '{7,  1'b1, 10'h3E0, 4'hF, 0, 2'd2, 5'h13, 1'b0, 1'b0};

        rst = 1'b1; rst3 = 1'b1; clk_en = 1'b0; clk_en3 = 1'b0;
        keyon = 1'b0; keyon3 = 1'b0; eg_att = 10'h3FF; sl = 4'h0;
        arate = 5'h11; rate1 = 5'h12; rate2 = 5'h13; rrate = 4'h7;
        clear_holds();
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 3, 0, 0, 0);
        rst = 1'b0;

        foreach (vecs[v]) begin
            goto_slot(vecs[v].slot);
            kon_hold[vecs[v].slot] = vecs[v].kon;
            att_hold[vecs[v].slot] = vecs[v].att;
            sl_hold[vecs[v].slot]  = vecs[v].sl;
            tick(vecs[v].kon, vecs[v].att, vecs[v].sl);
            check_out($sformatf("vec%0d", v), int'(vecs[v].e_state), int'(vecs[v].e_base),
                      int'(vecs[v].e_kon), int'(vecs[v].e_koff));
            if (vecs[v].stall > 0) begin
                clk_en = 1'b0;
                for (int c = 0; c < vecs[v].stall; c++) begin
                    keyon  = ~keyon;
                    eg_att = 10'($urandom);
                    @(posedge clk);
                    #1;
                    check_out($sformatf("stall%0d", c), int'(vecs[v].e_state), int'(vecs[v].e_base),
                              int'(vecs[v].e_kon), int'(vecs[v].e_koff));
                end
            end
        end

        // Asynchronous reset mid-frame, away from any clock edge.
        goto_slot(9);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_reset", 3, 0, 0, 0);
        @(posedge clk);
        #1;
        check_out("reset_held", 3, 0, 0, 0);
        rst = 1'b0;
        clear_holds();
        tick(1'b1, 10'h3FF, 4'h0);
        check_out("post_reset_slot0", 0, 17, 1, 0);
        tick(1'b0, 10'h3FF, 4'h0);
        check_out("post_reset_slot1", 3, 15, 0, 0);

        // 12-slot instance: context must come back after exactly 12 enabled cycles.
        clk_en  = 1'b0;
        rst3    = 1'b0;
        eg_att  = 10'h3FF;
        sl      = 4'h0;
        keyon3  = 1'b1;
        clk_en3 = 1'b1;
        @(posedge clk);
        #1;
        check_out3("n3_kon", 0, 17, 1, 0);
        keyon3 = 1'b0;
        for (int i = 1; i < 12; i++) begin
            @(posedge clk);
            #1;
            check(($sformatf("n3_idle%0d_kon", i)), int'(kon3), 0);
        end
        keyon3 = 1'b1;
        @(posedge clk);
        #1;
        check_out3("n3_wrap_held", 0, 17, 0, 0);
        keyon3 = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        keyon3 = 1'b0;
        @(posedge clk);
        #1;
        check_out3("n3_wrap_koff", 3, 15, 0, 1);
        clk_en3 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
